// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: arbiter state encodings, port-select constants and memory opcodes
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN0  = 2'd1,
    ARB_OWN1  = 2'd2,
    ARB_LOCK1 = 2'd3
  } arb_state_t;
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_P0 = 2'b01;
  localparam logic [1:0] SEL_P1 = 2'b10;
  localparam logic [9:0] FUNCT_LW = 10'h002;
  localparam logic [9:0] FUNCT_SW = 10'h102;
  localparam logic [3:0] STARVE_MAX = 4'hf;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select, port 0 first unless port 1 is starved or holds the lock
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       v0,
  input  logic       v1,
  input  logic [1:0] state,
  input  logic [3:0] starve_cnt,
  output logic [1:0] grant
);
  logic starve;
  // a locked port 1 owns the RAM; otherwise port 0 wins ties until port 1 has waited too long
  always_comb begin
    starve = starve_cnt >= 4'(STARVE_LIMIT);
    grant = state == ARB_LOCK1 ? SEL_P1 : v0 && !(v1 && starve) ? SEL_P0 : v1 ? SEL_P1 : SEL_NONE;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port single-RAM arbiter with port-1 lock; MEM_ARB_STARVE_GUARD_EN enables the port-1 starvation guard
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [9:0]  req0_funct,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  input  logic        req1_valid,
  input  logic        req1_lock,
  input  logic        req1_we,
  input  logic [9:0]  req1_funct,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic        ram_r_en,
  output logic        ram_w_en,
  output logic [9:0]  ram_funct,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [1:0]  arb_state
);
  arb_state_t state;
  logic [1:0] grant;
  logic hs0, hs1;
`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;
  // count port-0 wins taken while port 1 keeps waiting
  always_ff @(posedge clk)
    if (rst || hs1 || !req1_valid) starve_cnt <= '0;
    else if (hs0 && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 4'd1;
  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .v0(req0_valid),
    .v1(req1_valid),
    .state(state),
    .starve_cnt(starve_cnt),
    .grant(grant)
  );
`else
  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .v0(req0_valid),
    .v1(req1_valid),
    .state(state),
    .starve_cnt(4'd0),
    .grant(grant)
  );
`endif
  // ready follows the grant but is withheld under reset so no access can start
  always_comb begin
    req0_ready = grant[0] && !rst;
    req1_ready = grant[1] && !rst;
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    ram_r_en = hs0 ? !req0_we : hs1 && !req1_we;
    ram_w_en = hs0 ? req0_we : hs1 && req1_we;
    ram_funct = hs0 ? req0_funct : hs1 ? req1_funct : '0;
    ram_addr = hs0 ? req0_addr : hs1 ? req1_addr : '0;
    ram_wdata = hs0 ? req0_wdata : hs1 ? req1_wdata : '0;
  end
  // ownership state and one-cycle responses; read data is captured in the handshake cycle
  always_ff @(posedge clk)
    if (rst) begin
      state <= ARB_IDLE;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_rdata <= '0;
      resp1_rdata <= '0;
    end else begin
      state <= hs0 ? ARB_OWN0 : hs1 ? (req1_lock ? ARB_LOCK1 : ARB_OWN1) : ARB_IDLE;
      resp0_valid <= hs0;
      resp1_valid <= hs1;
      if (hs0 && !req0_we) resp0_rdata <= ram_rdata;
      if (hs1 && !req1_we) resp1_rdata <= ram_rdata;
    end
  assign arb_state = state;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 0, req0_we = 0, req0_ready, resp0_valid;
  logic [9:0] req0_funct = '0;
  logic [31:0] req0_addr = '0, req0_wdata = '0, resp0_rdata;
  logic req1_valid = 0, req1_lock = 0, req1_we = 0, req1_ready, resp1_valid;
  logic [9:0] req1_funct = '0;
  logic [31:0] req1_addr = '0, req1_wdata = '0, resp1_rdata;
  logic ram_r_en, ram_w_en;
  logic [9:0] ram_funct;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [1:0] arb_state;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] last0 = 0, last1 = 0;
  int total = 0, bad = 0;
  typedef struct {
    logic [1:0] p;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_funct(req0_funct),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_lock(req1_lock), .req1_we(req1_we), .req1_funct(req1_funct),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .ram_r_en(ram_r_en), .ram_w_en(ram_w_en), .ram_funct(ram_funct),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .arb_state(arb_state)
  );

  always #5 clk = ~clk;
  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge clk) if (ram_w_en) mem[ram_addr[9:2]] <= ram_wdata;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic beat(input logic v0, w0, input logic [31:0] a0, d0,
                      input logic v1, lk, w1, input logic [31:0] a1, d1,
                      input logic [1:0] eg, input logic [1:0] es);
    exp_t e;
    logic [1:0] hs;
    logic [9:0] f0, f1;
    @(negedge clk);
    if (q.size() > 0) e = q.pop_front();
    else e = '{p: 2'd0, d: 32'h0};
    chk("resp0_valid", resp0_valid, e.p == 2'd1);
    chk("resp1_valid", resp1_valid, e.p == 2'd2);
    if (e.p == 2'd1) chk("resp0_rdata", resp0_rdata, e.d);
    if (e.p == 2'd2) chk("resp1_rdata", resp1_rdata, e.d);
    f0 = w0 ? FUNCT_SW : FUNCT_LW;
    f1 = (w1 ? FUNCT_SW : FUNCT_LW) ^ 10'h200;
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0; req0_funct = f0;
    req1_valid = v1; req1_lock = lk; req1_we = w1; req1_addr = a1; req1_wdata = d1; req1_funct = f1;
    #1;
    chk("arb_state", arb_state, es);
    chk("ready", {req1_ready, req0_ready}, eg);
    hs = eg & {v1, v0};
    chk("ram_r_en", ram_r_en, hs[0] ? !w0 : hs[1] && !w1);
    chk("ram_w_en", ram_w_en, hs[0] ? w0 : hs[1] && w1);
    chk("ram_addr", ram_addr, hs[0] ? a0 : hs[1] ? a1 : 32'h0);
    chk("ram_funct", ram_funct, hs[0] ? f0 : hs[1] ? f1 : 10'h0);
    chk("ram_wdata", ram_wdata, hs[0] ? d0 : hs[1] ? d1 : 32'h0);
    if (hs[0]) begin
      if (w0) ref_mem[a0] = d0;
      else last0 = rd(a0);
      q.push_back('{p: 2'd1, d: last0});
    end else if (hs[1]) begin
      if (w1) ref_mem[a1] = d1;
      else last1 = rd(a1);
      q.push_back('{p: 2'd2, d: last1});
    end else q.push_back('{p: 2'd0, d: 32'h0});
  endtask

  task automatic idle(input logic [1:0] es);
    beat(0, 0, 0, 0, 0, 0, 0, 0, 0, SEL_NONE, es);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    req0_valid = 1; req0_we = 1; req0_addr = 32'h300; req0_wdata = 32'h0BAD0BAD;
    req1_valid = 1; req1_lock = 1; req1_we = 1; req1_addr = 32'h300; req1_wdata = 32'hBAD0BAD0;
    #1;
    chk("rst_r_en", ram_r_en, 0);
    chk("rst_w_en", ram_w_en, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    @(negedge clk);
    chk("rst_state", arb_state, ARB_IDLE);
    chk("rst_resp0_valid", resp0_valid, 0);
    chk("rst_resp1_valid", resp1_valid, 0);
    chk("rst_resp0_rdata", resp0_rdata, 0);
    chk("rst_resp1_rdata", resp1_rdata, 0);
    rst = 0;
    req0_valid = 0; req0_we = 0; req1_valid = 0; req1_lock = 0; req1_we = 0;
    q.delete();
    last0 = 0;
    last1 = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    do_reset();
    // port-0 store then load
    beat(1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, SEL_P0, ARB_IDLE);
    beat(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, SEL_P0, ARB_OWN0);
    idle(ARB_OWN0);
    // port-1 read and write, then port 0 reads port 1's data
    beat(0, 0, 0, 0, 1, 0, 0, 32'h100, 0, SEL_P1, ARB_IDLE);
    beat(0, 0, 0, 0, 1, 0, 1, 32'h104, 32'h12345678, SEL_P1, ARB_OWN1);
    beat(1, 0, 32'h104, 0, 0, 0, 0, 0, 0, SEL_P0, ARB_OWN1);
    // same-address collision: winner served, loser stays pending
    beat(1, 1, 32'h200, 32'hAAAA5555, 1, 0, 1, 32'h200, 32'h5555AAAA, SEL_P0, ARB_OWN0);
    beat(0, 0, 0, 0, 1, 0, 1, 32'h200, 32'h5555AAAA, SEL_P1, ARB_OWN0);
    beat(1, 0, 32'h200, 0, 0, 0, 0, 0, 0, SEL_P0, ARB_OWN1);
    idle(ARB_OWN0);
    idle(ARB_IDLE);
    // both ports requesting continuously
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 10; i++)
      beat(1, 0, 32'h100, 0, 1, 0, 0, 32'h104, 0, (i % 5 == 4) ? SEL_P1 : SEL_P0,
           i == 0 ? ARB_IDLE : (i % 5 == 0) ? ARB_OWN1 : ARB_OWN0);
    idle(ARB_OWN1);
`else
    for (int i = 0; i < 20; i++)
      beat(1, 0, 32'h100, 0, 1, 0, 0, 32'h104, 0, SEL_P0, i == 0 ? ARB_IDLE : ARB_OWN0);
    idle(ARB_OWN0);
`endif
    idle(ARB_IDLE);
    // port-1 lock holds off port 0 until the lock drops
    beat(0, 0, 0, 0, 1, 1, 0, 32'h100, 0, SEL_P1, ARB_IDLE);
    for (int i = 0; i < 3; i++) beat(1, 0, 32'h104, 0, 1, 1, 0, 32'h100, 0, SEL_P1, ARB_LOCK1);
    beat(1, 0, 32'h104, 0, 0, 0, 0, 0, 0, SEL_P1, ARB_LOCK1);
    beat(1, 0, 32'h104, 0, 0, 0, 0, 0, 0, SEL_P0, ARB_IDLE);
    idle(ARB_OWN0);
    // reset while locked with a port-1 read response outstanding
    beat(0, 0, 0, 0, 1, 1, 0, 32'h100, 0, SEL_P1, ARB_IDLE);
    beat(0, 0, 0, 0, 1, 1, 0, 32'h104, 0, SEL_P1, ARB_LOCK1);
    do_reset();
    beat(1, 0, 32'h300, 0, 0, 0, 0, 0, 0, SEL_P0, ARB_IDLE);
    idle(ARB_OWN0);
    idle(ARB_IDLE);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive port-0 grants permitted while port 1 waits (range 1..15).
REQ-002 SHALL have port clk, input, 1: single clock; every register updates on posedge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port 0 inputs from the memory-access stage: req0_valid (1), req0_we (1), req0_funct (10), req0_addr (32) and req0_wdata (32).
REQ-005 SHALL have port 0 outputs req0_ready (1), resp0_valid (1) and resp0_rdata (32).
REQ-006 SHALL have port 1 inputs from the debug/DMA requester: req1_valid (1), req1_lock (1), req1_we (1), req1_funct (10), req1_addr (32) and req1_wdata (32).
REQ-007 SHALL have port 1 outputs req1_ready (1), resp1_valid (1) and resp1_rdata (32).
REQ-008 SHALL have RAM-side outputs ram_r_en (1), ram_w_en (1), ram_funct (10), ram_addr (32) and ram_wdata (32), plus input ram_rdata (32), which is the combinational read data for the presented address.
REQ-009 SHALL have output arb_state (2): the current FSM state, for debug.

Function
REQ-010 SHALL accept a request on port n only in a cycle where reqn_valid && reqn_ready (a handshake), and SHALL assert ready on at most one port per cycle.
REQ-011 SHALL drive the RAM outputs combinationally from the granted port in the handshake cycle; with no handshake, ram_r_en=0, ram_w_en=0, and ram_addr, ram_wdata and ram_funct are 0.
REQ-012 SHALL assert ram_r_en=~we and ram_w_en=we for the granted request; a write commits at the posedge ending the handshake cycle.
REQ-013 SHALL deliver responses with 1-cycle latency: in the cycle after a handshake, respn_valid=1; for a read, respn_rdata = ram_rdata captured in the handshake cycle; for a write, respn_rdata holds its previous value. Responses have no backpressure.
REQ-014 SHALL implement FSM IDLE(0), OWN0(1), OWN1(2) and LOCK1(3); arb_state reflects the registered state.
REQ-015 SHALL select, in IDLE/OWN0/OWN1, port 0 when only req0_valid is set and port 1 when only req1_valid is set; when both are set it SHALL select port 0 unless the starvation rule (REQ-018) applies.
REQ-016 SHALL make FSM next-state transitions as follows: handshake on port 0 → OWN0; handshake on port 1 with req1_lock=1 → LOCK1; handshake on port 1 with req1_lock=0 → OWN1; no handshake → IDLE.
REQ-017 SHALL, in LOCK1, give req0_ready=0 and req1_ready=1; it SHALL stay in LOCK1 while req1_valid && req1_lock, and otherwise exit through the REQ-016 rules, port 1 keeping priority for that cycle.
REQ-018 SHALL keep a 4-bit starve_cnt: +1 per port-0 handshake while req1_valid=1; cleared on any port-1 handshake or when req1_valid=0; saturates at 15. When starve_cnt >= STARVE_LIMIT and both ports request, port 1 wins.
REQ-019 SHALL, on a same-cycle request from both ports to the same address, serve only the winner; the loser's request stays pending with its ready low.

Reset
REQ-020 SHALL, when rst=1 at posedge, set state to IDLE, starve_cnt to 0, resp0_valid and resp1_valid to 0, and resp0_rdata and resp1_rdata to 32'h0.
REQ-021 SHALL give priority to reset mid-operation, including during LOCK1 or with a response pending: the pending response is dropped and no RAM enable is asserted in any cycle where rst=1.

Configuration
REQ-022 SHALL, with macro MEM_ARB_STARVE_GUARD_EN defined, implement starve_cnt and REQ-018 as specified.
REQ-023 SHALL, with MEM_ARB_STARVE_GUARD_EN undefined, omit starve_cnt and use strict port-0 priority, with LOCK1 still supported; STARVE_LIMIT is then ignored.

Structure
REQ-024 SHALL place the FSM state encodings (ARB_IDLE..ARB_LOCK1) and the port-select constants in the shared package/define file alongside the opcode defines.
REQ-025 SHALL implement the winner/starvation decision as a combinational sub-module mem_arb_pick (inputs: valids, state, starve_cnt; output: grant one-hot); the FSM and response registers stay in the top module.

Verification
REQ-026 SHALL cover port-0 store then load: write 32'hDEADBEEF at addr 0x100, read 0x100 → resp0_valid the cycle after the read handshake with resp0_rdata=32'hDEADBEEF.
REQ-027 SHALL cover simultaneous requests with the guard enabled and STARVE_LIMIT=4: both ports request continuously → grants 0,0,0,0,1,0,0,0,0,1…
REQ-028 SHALL cover port-1 lock: req1_lock=1 for 3 beats while req0_valid=1 → req0_ready=0 for those 3 cycles, arb_state=3, and port 0 is granted on the cycle after the lock drops.
REQ-029 SHALL cover reset in LOCK1 with a read response pending: next cycle state=IDLE, resp1_valid=0, and no ram_w_en.
REQ-030 SHALL cover the guard disabled (macro undefined): both ports request for 20 cycles → port 1 never granted and arb_state never equals 2.
